// File: rtl/rs_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pool_pkg
// Description : Shared widths, tag-null constant and picker helper for the
//               reservation-station pool.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pool_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int TAG_NULL  = 0;
    localparam int MAX_DEPTH = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Lowest set bit of a pool-sized vector.
    function automatic pick_t find_first(input logic [MAX_DEPTH-1:0] v);
        pick_t p;
        p = '0;
        for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                p.found = 1'b1;
                p.idx   = 5'(i);
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_pool_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_pool_if
// Description : Allocation, CDB broadcast and issue bundle of the pool.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_pool_if
    import rs_pool_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
);
    localparam int FCW = $clog2(DEPTH + 1);

    logic                      rdy;
    logic                      flush;

    logic                      alloc_en0;
    logic [OP_W-1:0]           alloc_op0;
    logic [TAG_W-1:0]          alloc_tagx0;
    logic [TAG_W-1:0]          alloc_tagy0;
    logic [TAG_W-1:0]          alloc_tagw0;
    logic [DATA_W-1:0]         alloc_datax0;
    logic [DATA_W-1:0]         alloc_datay0;
    logic [ADDR_W-1:0]         alloc_addrw0;

    logic                      alloc_en1;
    logic [OP_W-1:0]           alloc_op1;
    logic [TAG_W-1:0]          alloc_tagx1;
    logic [TAG_W-1:0]          alloc_tagy1;
    logic [TAG_W-1:0]          alloc_tagw1;
    logic [DATA_W-1:0]         alloc_datax1;
    logic [DATA_W-1:0]         alloc_datay1;
    logic [ADDR_W-1:0]         alloc_addrw1;

    logic                      alloc_ready0;
    logic                      alloc_ready1;
    logic [FCW-1:0]            free_cnt;

    logic [NUM_CDB-1:0]        cdb_en;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;

    logic                      iss_valid;
    logic                      iss_ready;
    logic [OP_W-1:0]           iss_op;
    logic [DATA_W-1:0]         iss_datax;
    logic [DATA_W-1:0]         iss_datay;
    logic [TAG_W-1:0]          iss_tagw;
    logic [ADDR_W-1:0]         iss_addrw;

    modport slave (
        input  rdy, flush,
        input  alloc_en0, alloc_op0, alloc_tagx0, alloc_tagy0, alloc_tagw0,
               alloc_datax0, alloc_datay0, alloc_addrw0,
        input  alloc_en1, alloc_op1, alloc_tagx1, alloc_tagy1, alloc_tagw1,
               alloc_datax1, alloc_datay1, alloc_addrw1,
        output alloc_ready0, alloc_ready1, free_cnt,
        input  cdb_en, cdb_tag, cdb_data,
        output iss_valid, iss_op, iss_datax, iss_datay, iss_tagw, iss_addrw,
        input  iss_ready
    );

    modport master (
        output rdy, flush,
        output alloc_en0, alloc_op0, alloc_tagx0, alloc_tagy0, alloc_tagw0,
               alloc_datax0, alloc_datay0, alloc_addrw0,
        output alloc_en1, alloc_op1, alloc_tagx1, alloc_tagy1, alloc_tagw1,
               alloc_datax1, alloc_datay1, alloc_addrw1,
        input  alloc_ready0, alloc_ready1, free_cnt,
        output cdb_en, cdb_tag, cdb_data,
        input  iss_valid, iss_op, iss_datax, iss_datay, iss_tagw, iss_addrw,
        output iss_ready
    );

endinterface
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
// Module      : rs_entry
// Description : One reservation-station slot with NUM_CDB-way operand wakeup.
//               RS_WAKEUP_BYPASS_EN makes a slot issue-eligible in the cycle
//               its last operand is broadcast, forwarding the CDB data.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_entry
    import rs_pool_pkg::*;
#(
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic                      clr,
    input  logic [OP_W-1:0]           wr_op,
    input  logic [TAG_W-1:0]          wr_tagx,
    input  logic [TAG_W-1:0]          wr_tagy,
    input  logic [TAG_W-1:0]          wr_tagw,
    input  logic [DATA_W-1:0]         wr_datax,
    input  logic [DATA_W-1:0]         wr_datay,
    input  logic [ADDR_W-1:0]         wr_addrw,
    input  logic [NUM_CDB-1:0]        cdb_en,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      busy,
    output logic                      iss_rdy,
    output logic [OP_W-1:0]           op,
    output logic [DATA_W-1:0]         iss_datax,
    output logic [DATA_W-1:0]         iss_datay,
    output logic [TAG_W-1:0]          tagw,
    output logic [ADDR_W-1:0]         addrw
);

    localparam logic [TAG_W-1:0] TAG_ZERO = TAG_W'(TAG_NULL);

    // Returns {hit, data}; scanning downwards lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        en,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (en[k] && (tag != TAG_ZERO) && (tags[k*TAG_W +: TAG_W] == tag))
                r = {1'b1, data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic              busy_q,  busy_d;
    logic [OP_W-1:0]   op_q,    op_d;
    logic [TAG_W-1:0]  tagx_q,  tagx_d;
    logic [TAG_W-1:0]  tagy_q,  tagy_d;
    logic [TAG_W-1:0]  tagw_q,  tagw_d;
    logic [DATA_W-1:0] datax_q, datax_d;
    logic [DATA_W-1:0] datay_q, datay_d;
    logic [ADDR_W-1:0] addrw_q, addrw_d;

    logic [DATA_W:0]   hit_x, hit_y, hit_ax, hit_ay;

    always_comb begin
        hit_x   = cdb_lookup(tagx_q,  cdb_en, cdb_tag, cdb_data);
        hit_y   = cdb_lookup(tagy_q,  cdb_en, cdb_tag, cdb_data);
        hit_ax  = cdb_lookup(wr_tagx, cdb_en, cdb_tag, cdb_data);
        hit_ay  = cdb_lookup(wr_tagy, cdb_en, cdb_tag, cdb_data);

        busy_d  = busy_q;
        op_d    = op_q;
        tagx_d  = tagx_q;
        tagy_d  = tagy_q;
        tagw_d  = tagw_q;
        datax_d = datax_q;
        datay_d = datay_q;
        addrw_d = addrw_q;

        if (flush) begin
            busy_d = 1'b0;
            tagx_d = TAG_ZERO;
            tagy_d = TAG_ZERO;
        end else if (clr) begin
            busy_d = 1'b0;
        end else if (wr_en) begin
            busy_d  = 1'b1;
            op_d    = wr_op;
            tagw_d  = wr_tagw;
            addrw_d = wr_addrw;
            tagx_d  = hit_ax[DATA_W] ? TAG_ZERO : wr_tagx;
            tagy_d  = hit_ay[DATA_W] ? TAG_ZERO : wr_tagy;
            datax_d = hit_ax[DATA_W] ? hit_ax[DATA_W-1:0] : wr_datax;
            datay_d = hit_ay[DATA_W] ? hit_ay[DATA_W-1:0] : wr_datay;
        end else if (busy_q) begin
            if (hit_x[DATA_W]) begin
                tagx_d  = TAG_ZERO;
                datax_d = hit_x[DATA_W-1:0];
            end
            if (hit_y[DATA_W]) begin
                tagy_d  = TAG_ZERO;
                datay_d = hit_y[DATA_W-1:0];
            end
        end
    end

    // rdy acts as a global clock enable: nothing moves while it is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            op_q    <= '0;
            tagx_q  <= TAG_ZERO;
            tagy_q  <= TAG_ZERO;
            tagw_q  <= '0;
            datax_q <= '0;
            datay_q <= '0;
            addrw_q <= '0;
        end else if (rdy) begin
            busy_q  <= busy_d;
            op_q    <= op_d;
            tagx_q  <= tagx_d;
            tagy_q  <= tagy_d;
            tagw_q  <= tagw_d;
            datax_q <= datax_d;
            datay_q <= datay_d;
            addrw_q <= addrw_d;
        end
    end

    assign busy  = busy_q;
    assign op    = op_q;
    assign tagw  = tagw_q;
    assign addrw = addrw_q;

`ifdef RS_WAKEUP_BYPASS_EN
    assign iss_rdy   = busy_q
                     && ((tagx_q == TAG_ZERO) || hit_x[DATA_W])
                     && ((tagy_q == TAG_ZERO) || hit_y[DATA_W]);
    assign iss_datax = hit_x[DATA_W] ? hit_x[DATA_W-1:0] : datax_q;
    assign iss_datay = hit_y[DATA_W] ? hit_y[DATA_W-1:0] : datay_q;
`else
    assign iss_rdy   = busy_q && (tagx_q == TAG_ZERO) && (tagy_q == TAG_ZERO);
    assign iss_datax = datax_q;
    assign iss_datay = datay_q;
`endif

endmodule
`default_nettype wire

// File: rtl/rs_pool.sv
`default_nettype none
// ============================================================================
// Module      : rs_pool
// Description : DEPTH-entry reservation station with dual allocate, CDB
//               wakeup and lowest-index issue. Option: RS_WAKEUP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_pool
    import rs_pool_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic     clk,
    input  logic     rst,
    rs_pool_if.slave bus
);

    localparam int FCW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     iss_rdy;
    logic [OP_W-1:0]      op_arr    [DEPTH];
    logic [DATA_W-1:0]    datax_arr [DEPTH];
    logic [DATA_W-1:0]    datay_arr [DEPTH];
    logic [TAG_W-1:0]     tagw_arr  [DEPTH];
    logic [ADDR_W-1:0]    addrw_arr [DEPTH];

    logic [MAX_DEPTH-1:0] free_vec;
    pick_t                free0, free1, iss_pick;
    logic                 alloc0_go, alloc1_go;
    logic [4:0]           alloc1_idx;
    logic                 iss_fire;
    logic [FCW-1:0]       free_cnt;

    // Pickers look only at registered busy bits, so an entry issuing this
    // cycle is never offered for allocation in the same cycle.
    always_comb begin
        free_vec             = '0;
        free_vec[DEPTH-1:0]  = ~busy;
        free0                = find_first(free_vec);
        free1                = find_first(free_vec & ~(MAX_DEPTH'(1) << free0.idx));
        alloc0_go            = bus.rdy && !bus.flush && bus.alloc_en0 && free0.found;
        alloc1_go            = bus.rdy && !bus.flush && bus.alloc_en1 && free1.found;
        alloc1_idx           = alloc0_go ? free1.idx : free0.idx;
        iss_pick             = find_first(MAX_DEPTH'(iss_rdy));
        iss_fire             = bus.rdy && !bus.flush && bus.iss_ready && iss_pick.found;
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            free_cnt = free_cnt + {{(FCW-1){1'b0}}, ~busy[i]};
    end

    assign bus.alloc_ready0 = free0.found;
    assign bus.alloc_ready1 = free1.found;
    assign bus.free_cnt     = free_cnt;
    assign bus.iss_valid    = bus.rdy && iss_pick.found;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic sel0, sel1, clr;

            assign sel0 = alloc0_go && (free0.idx == 5'(i));
            assign sel1 = alloc1_go && (alloc1_idx == 5'(i));
            assign clr  = iss_fire && (iss_pick.idx == 5'(i));

            rs_entry #(
                .NUM_CDB (NUM_CDB),
                .TAG_W   (TAG_W),
                .OP_W    (OP_W)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .rdy       (bus.rdy),
                .flush     (bus.flush),
                .wr_en     (sel0 | sel1),
                .clr       (clr),
                .wr_op     (sel0 ? bus.alloc_op0    : bus.alloc_op1),
                .wr_tagx   (sel0 ? bus.alloc_tagx0  : bus.alloc_tagx1),
                .wr_tagy   (sel0 ? bus.alloc_tagy0  : bus.alloc_tagy1),
                .wr_tagw   (sel0 ? bus.alloc_tagw0  : bus.alloc_tagw1),
                .wr_datax  (sel0 ? bus.alloc_datax0 : bus.alloc_datax1),
                .wr_datay  (sel0 ? bus.alloc_datay0 : bus.alloc_datay1),
                .wr_addrw  (sel0 ? bus.alloc_addrw0 : bus.alloc_addrw1),
                .cdb_en    (bus.cdb_en),
                .cdb_tag   (bus.cdb_tag),
                .cdb_data  (bus.cdb_data),
                .busy      (busy[i]),
                .iss_rdy   (iss_rdy[i]),
                .op        (op_arr[i]),
                .iss_datax (datax_arr[i]),
                .iss_datay (datay_arr[i]),
                .tagw      (tagw_arr[i]),
                .addrw     (addrw_arr[i])
            );
        end
    endgenerate

    always_comb begin
        bus.iss_op    = op_arr[0];
        bus.iss_datax = datax_arr[0];
        bus.iss_datay = datay_arr[0];
        bus.iss_tagw  = tagw_arr[0];
        bus.iss_addrw = addrw_arr[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (iss_pick.idx == 5'(i)) begin
                bus.iss_op    = op_arr[i];
                bus.iss_datax = datax_arr[i];
                bus.iss_datay = datay_arr[i];
                bus.iss_tagw  = tagw_arr[i];
                bus.iss_addrw = addrw_arr[i];
            end
        end
    end

endmodule
`default_nettype wire
